// File: rtl/mod_mul_pkg.sv
// mod_mul_pkg: shared constants and state encoding for the modular-multiplier scheduler.
`default_nettype none

package mod_mul_pkg;

  localparam int   Q               = 3329;
  localparam logic MODE_BARRETT    = 1'b1;
  localparam logic MODE_CONV       = 1'b0;
  localparam int   DEFAULT_MUL_LAT = 5;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/mod_mul_inflight_pipe.sv
// mod_mul_inflight_pipe: valid/port/tag delay line tracking operations inside the multiplier.
`default_nettype none

module mod_mul_inflight_pipe #(
  parameter int DEPTH = 6,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_port,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic             out_port,
  output logic [TAG_W-1:0] out_tag,
  output logic             empty
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] prt;
  logic [TAG_W-1:0] tg [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      prt <= '0;
      for (int i = 0; i < DEPTH; i++) tg[i] <= '0;
    end else begin
      vld   <= {vld[DEPTH-2:0], in_valid};
      prt   <= {prt[DEPTH-2:0], in_port};
      tg[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) tg[i] <= tg[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_port  = prt[DEPTH-1];
  assign out_tag   = tg[DEPTH-1];
  assign empty     = ~|vld;

endmodule

`default_nettype wire

// File: rtl/mod_mul_scheduler.sv
// mod_mul_scheduler: round-robin arbiter of two requesters onto one shared modular multiplier,
// draining the pipeline whenever the multiplier mode (sel) must change.
`default_nettype none

module mod_mul_scheduler
  import mod_mul_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [1:0]          req_mode,
  input  logic [2*TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  output logic                mul_sel,
  input  logic [DATA_W-1:0]   mul_c,
  output logic                rsp_valid,
  output logic                rsp_port,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                busy
);

  sched_state_e state, state_nxt;
  logic         rr;
  logic         lock, lock_nxt;
  logic         win;
  logic         issue;
  logic         issue_port;
  logic         trk_empty;
  logic         trk_valid;
  logic         trk_port;
  logic [TAG_W-1:0]  trk_tag;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_mode;

  // Lone requester wins outright; contention resolved by the round-robin pointer.
  assign win = (req_valid == 2'b11) ? rr : req_valid[1];

  always_comb begin
    state_nxt  = state;
    lock_nxt   = lock;
    issue      = 1'b0;
    issue_port = win;
    req_ready  = 2'b00;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (|req_valid) begin
            if ((req_mode[win] == mul_sel) || trk_empty) begin
              issue = 1'b1;
            end else begin
              lock_nxt  = win;
              state_nxt = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          issue_port = lock;
          if (!req_valid[lock]) begin
            state_nxt = ST_RUN;
          end else if (trk_empty) begin
            issue     = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    req_ready[issue_port] = issue;
  end

  assign sel_a    = issue_port ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign sel_b    = issue_port ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign sel_tag  = issue_port ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  assign sel_mode = req_mode[issue_port];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      rr      <= 1'b0;
      lock    <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sel <= MODE_BARRETT;
    end else begin
      state <= state_nxt;
      lock  <= lock_nxt;
      if (issue) begin
        rr      <= ~issue_port;
        mul_a   <= sel_a;
        mul_b   <= (sel_mode == MODE_CONV) ? '0 : sel_b;
        mul_sel <= sel_mode;
      end
    end
  end

  // One extra stage beyond MUL_LAT so the tail entry lines up with mul_c.
  mod_mul_inflight_pipe #(
    .DEPTH (MUL_LAT + 1),
    .TAG_W (TAG_W)
  ) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_port   (issue_port),
    .in_tag    (sel_tag),
    .out_valid (trk_valid),
    .out_port  (trk_port),
    .out_tag   (trk_tag),
    .empty     (trk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= trk_valid;
      if (trk_valid) begin
        rsp_port <= trk_port;
        rsp_tag  <= trk_tag;
        rsp_data <= mul_c;
      end
    end
  end

  assign busy = ~trk_empty | (|req_valid) | (state == ST_DRAIN);

endmodule

`default_nettype wire
